// File: rtl/booth_divider_if.sv
// Request/response bundle for the signed sequential divider.
interface booth_divider_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         start;
  logic [N-1:0] Z;
  logic [M-1:0] Y;
  logic         busy;
  logic         valid;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         dz;
  logic         ovf;

  modport master (
    output start, Z, Y,
    input  busy, valid, Q, R, dz, ovf
  );

  modport slave (
    input  start, Z, Y,
    output busy, valid, Q, R, dz, ovf
  );
endinterface

// File: rtl/booth_divider.sv
// Signed truncating divider: magnitude restoring shift-subtract over N cycles,
// followed by a single sign/exception fix-up cycle. Fixed latency N+1 edges.
// N is expected to be at least 2.
module booth_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic             clk,
  input  logic             rst,
  booth_divider_if.slave   bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quo;     // holds |Z| initially, quotient bits shift in at the LSB
  logic [M:0]     r_prem;    // partial remainder, one bit wider than |Y|
  logic [M-1:0]   r_ymag;
  logic           r_sz, r_sy, r_yz;
  logic           r_busy, r_valid, r_dz, r_ovf;
  logic [N-1:0]   r_q;
  logic [M-1:0]   r_r;

  logic           w_last;
  logic [N-1:0]   w_zmag;
  logic [M-1:0]   w_ymag;
  logic [M:0]     w_shift;
  logic [M+1:0]   w_diff;
  logic           w_ge;
  logic           w_negq;
  logic [N-1:0]   w_qs;
  logic [M-1:0]   w_rs;
  logic           w_ovf;

  // Magnitudes kept unsigned, so the most negative value maps to 2^(width-1).
  assign w_zmag  = bus.Z[N-1] ? -bus.Z : bus.Z;
  assign w_ymag  = bus.Y[M-1] ? -bus.Y : bus.Y;

  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_shift = {r_prem[M-1:0], r_quo[N-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_ymag};
  assign w_ge    = ~w_diff[M+1];

  assign w_negq  = r_sz ^ r_sy;
  assign w_qs    = w_negq ? -r_quo : r_quo;
  assign w_rs    = r_sz ? -r_prem[M-1:0] : r_prem[M-1:0];
  // A positive quotient with its top bit set only arises from -2^(N-1) / -1.
  assign w_ovf   = ~w_negq & r_quo[N-1] & ~r_yz;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = CALC;
      CALC:    if (w_last)    w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_prem  <= '0;
      r_ymag  <= '0;
      r_sz    <= 1'b0;
      r_sy    <= 1'b0;
      r_yz    <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_quo  <= w_zmag;
            r_ymag <= w_ymag;
            r_sz   <= bus.Z[N-1];
            r_sy   <= bus.Y[M-1];
            r_yz   <= (bus.Y == '0);
            r_prem <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        CALC: begin
          if (w_ge) r_prem <= w_diff[M:0];
          else      r_prem <= w_shift;
          r_quo <= {r_quo[N-2:0], w_ge};
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        FIX: begin
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_dz    <= r_yz;
          r_ovf   <= w_ovf;
          if (r_yz) begin
            r_q <= '0;
            r_r <= '0;
          end else if (w_ovf) begin
            r_q <= {1'b0, {(N-1){1'b1}}};
            r_r <= '0;
          end else begin
            r_q <= w_qs;
            r_r <= w_rs;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.Q     = r_q;
  assign bus.R     = r_r;
  assign bus.dz    = r_dz;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider (N=8, M=4).
module tb_booth_divider;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  booth_divider_if #(.N(N), .M(M)) bus ();

  booth_divider #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int eq, input int er,
                         input int edz, input int eovf);
    chk({tag, ".Q"},   int'($signed(bus.Q)), eq);
    chk({tag, ".R"},   int'($signed(bus.R)), er);
    chk({tag, ".dz"},  int'(bus.dz),  edz);
    chk({tag, ".ovf"}, int'(bus.ovf), eovf);
  endtask

  // Single operation: pulse start, scramble operands after acceptance,
  // check latency, result, busy drop, valid fall and hold.
  task automatic op(input string tag, input int z, input int y, input int eq,
                    input int er, input int edz, input int eovf);
    int k;
    @(negedge clk);
    bus.Z = z[N-1:0];
    bus.Y = y[M-1:0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.Z = ~bus.Z;
    bus.Y = ~bus.Y;
    chk({tag, ".busy"}, int'(bus.busy), 1);
    k = 0;
    while (!bus.valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, ".lat"}, k, N + 1);
    chk_res(tag, eq, er, edz, eovf);
    chk({tag, ".idle"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    chk({tag, ".vfall"}, int'(bus.valid), 0);
    chk_res({tag, ".hold"}, eq, er, edz, eovf);
  endtask

  initial begin
    int k;
    int nv;
    bus.start = 1'b0;
    bus.Z = '0;
    bus.Y = '0;
    #1;
    chk("rst.busy",  int'(bus.busy), 0);
    chk("rst.valid", int'(bus.valid), 0);
    chk_res("rst", 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    op("p35_5",    35,   5,    7,  0, 0, 0);
    op("m24_6",   -24,   6,   -4,  0, 0, 0);
    op("m7_2",     -7,   2,   -3, -1, 0, 0);
    op("p7_m2",     7,  -2,   -3,  1, 0, 0);
    op("m128_m1", -128, -1,  127,  0, 0, 1);
    op("m128_1",  -128,  1, -128,  0, 0, 0);
    op("m128_m8", -128, -8,   16,  0, 0, 0);
    op("p5_0",      5,   0,    0,  0, 1, 0);

    // Start held high: back-to-back operations 10 cycles apart.
    @(negedge clk);
    bus.Z = 8'd35;
    bus.Y = 4'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.Z = 8'd1;
    bus.Y = 4'd3;
    k = 0;
    while (!bus.valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("cont.lat1", k, N + 1);
    chk_res("cont.r1", 7, 0, 0, 0);
    bus.Z = 8'd35;
    bus.Y = 4'd5;
    @(posedge clk); #1;
    chk("cont.busy2", int'(bus.busy), 1);
    bus.Z = 8'd100;
    bus.Y = 4'd7;
    k = 1;
    while (!bus.valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    chk("cont.gap", k, N + 2);
    chk_res("cont.r2", 7, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("cont.stop", int'(bus.busy), 0);

    // Reset four cycles into CALC aborts the operation.
    op("pre_rst", 35, 5, 7, 0, 0, 0);
    @(negedge clk);
    bus.Z = 8'd35;
    bus.Y = 4'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort.busy",  int'(bus.busy), 0);
    chk("abort.valid", int'(bus.valid), 0);
    chk_res("abort", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.valid) nv++;
    end
    chk("abort.novalid", nv, 0);
    op("p12_m5", 12, -5, -2, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_divider.md
BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 SHALL provide parameter N, default 8, dividend and quotient width in bits.
REQ-002 SHALL provide parameter M, default 4, divisor and remainder width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Z  input  N  signed dividend (two's complement).
REQ-007 SHALL have port Y  input  M  signed divisor (two's complement).
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port valid  output  1  one-cycle pulse: Q/R/dz/ovf just updated.
REQ-010 SHALL have port Q  output  N  signed quotient.
REQ-011 SHALL have port R  output  M  signed remainder.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag for the last result.
REQ-013 SHALL have port ovf  output  1  quotient overflow flag for the last result.

Function
REQ-014 SHALL compute truncating signed division: Q = trunc(Z/Y), R = Z - Q*Y; R sign follows Z, |R| < |Y|.
REQ-015 SHALL use the FSM states IDLE, CALC, FIX only.
REQ-016 IDLE with start=1 at edge E0: SHALL capture |Z| (N-bit unsigned), |Y| (M-bit unsigned), sign(Z), sign(Y), and Y==0; set busy=1; go to CALC.
REQ-017 CALC SHALL run exactly N iterations, one quotient bit per cycle, MSB first, restoring shift-subtract on an (M+1)-bit partial remainder; iteration counter wraps to FIX after the N-th.
REQ-018 FIX SHALL apply signs (Q negated if sign(Z)!=sign(Y), R negated if sign(Z)=1), register Q/R/dz/ovf, pulse valid, clear busy, and return to IDLE in one cycle.
REQ-019 valid SHALL rise at edge E0+N+1 and fall at edge E0+N+2; latency SHALL be fixed regardless of operand values, including dz and ovf cases.
REQ-020 Q, R, dz, ovf SHALL hold their values from valid until the next FIX cycle.
REQ-021 start SHALL be ignored while busy=1; Z and Y SHALL be don't-care after E0.
REQ-022 A start high in the same cycle as valid SHALL be ignored; the earliest accepted restart SHALL be at edge E0+N+2.
REQ-023 Y==0: SHALL produce dz=1, ovf=0, Q=0, R=0.
REQ-024 Z = -2^(N-1) with Y = -1: SHALL produce ovf=1, dz=0, Q = 2^(N-1)-1 (saturated), R=0.
REQ-025 In all other cases, dz=0 and ovf=0.
REQ-026 Magnitudes SHALL be computed without loss: |-2^(N-1)| SHALL be represented as unsigned 2^(N-1), and |-2^(M-1)| likewise.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, busy=0, valid=0, Q=0, R=0, dz=0, ovf=0, and iteration counter=0.
REQ-028 Reset asserted mid-CALC or mid-FIX SHALL abort the operation; no valid pulse SHALL follow the abort.
REQ-029 After rst deasserts, the first start SHALL be accepted at the next rising edge in IDLE.

Verification
REQ-030 Z=35, Y=5, start pulse -> valid exactly 9 edges after sampling, Q=7, R=0, dz=0, ovf=0.
REQ-031 Z=-24, Y=6 -> Q=-4, R=0; Z=-7, Y=2 -> Q=-3, R=-1; Z=7, Y=-2 -> Q=-3, R=1.
REQ-032 Z=-128, Y=-1 -> Q=127, R=0, ovf=1; Z=-128, Y=1 -> Q=-128, R=0, ovf=0; Z=-128, Y=-8 -> Q=16, R=0.
REQ-033 Z=5, Y=0 -> dz=1, Q=0, R=0, valid at the same latency of 9 edges.
REQ-034 Start held high continuously with Z=35, Y=5 -> valid pulses separated by 10 cycles; changing Z/Y while busy leaves the result unaffected.
REQ-035 rst pulsed low 4 cycles into CALC -> outputs zero at once, no valid pulse; next start with Z=12, Y=-5 -> Q=-2, R=2.
